// File: rtl/ram_wb_adapter_pkg.sv
// ram_wb_adapter_pkg: FSM states, Wishbone CTI/BTE codes and byte-lane merge for ram_wb_adapter
// Build option RAM_WB_BURST_EN adds the BURST state.
package ram_wb_adapter_pkg;
   localparam int dat_width = 32;
`ifdef RAM_WB_BURST_EN
   typedef enum logic [2:0] {IDLE, RD, RMW, ACK, BURST} state_t;
`else
   typedef enum logic [2:0] {IDLE, RD, RMW, ACK} state_t;
`endif
   localparam logic [2:0] cti_classic = 3'b000;
   localparam logic [2:0] cti_incr    = 3'b010;
   localparam logic [2:0] cti_end     = 3'b111;
   localparam logic [1:0] bte_linear  = 2'b00;
   localparam logic [1:0] bte_wrap4   = 2'b01;
   localparam logic [1:0] bte_wrap8   = 2'b10;
   localparam logic [1:0] bte_wrap16  = 2'b11;
   function automatic logic [dat_width-1:0] merge_bytes(input logic [dat_width-1:0] old_dat,
                                                        input logic [dat_width-1:0] new_dat,
                                                        input logic [3:0]           sel);
      logic [dat_width-1:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? new_dat[8*i +: 8] : old_dat[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/ram_wb_adapter_if.sv
// ram_wb_adapter_if: Wishbone responder bus plus raw SRAM port of ram_wb_adapter
// slave: adapter side (drives wb_dat_o/ack/err and ram_adr_o/ram_dat_o/ram_we_o)
// master: interconnect/RAM side (drives wb request signals and ram_dat_i)
interface ram_wb_adapter_if import ram_wb_adapter_pkg::*; #(parameter int adr_width = 20);
   logic [31:0]          wb_adr_i;
   logic [dat_width-1:0] wb_dat_i;
   logic [3:0]           wb_sel_i;
   logic                 wb_we_i;
   logic                 wb_cyc_i;
   logic                 wb_stb_i;
   logic [2:0]           wb_cti_i;
   logic [1:0]           wb_bte_i;
   logic [dat_width-1:0] wb_dat_o;
   logic                 wb_ack_o;
   logic                 wb_err_o;
   logic [adr_width-1:0] ram_adr_o;
   logic [dat_width-1:0] ram_dat_o;
   logic                 ram_we_o;
   logic [dat_width-1:0] ram_dat_i;
   modport slave (input wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i, ram_dat_i,
                  output wb_dat_o, wb_ack_o, wb_err_o, ram_adr_o, ram_dat_o, ram_we_o);
   modport master (output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i, ram_dat_i,
                   input wb_dat_o, wb_ack_o, wb_err_o, ram_adr_o, ram_dat_o, ram_we_o);
endinterface

// File: rtl/ram_wb_burst_addr.sv
// ram_wb_burst_addr: next word address of a Wishbone incrementing burst (linear or 4/8/16 wrap)
// adr: current word address; bte: burst type; next_adr: following word address
module ram_wb_burst_addr import ram_wb_adapter_pkg::*; #(parameter int adr_width = 20) (
   input  logic [adr_width-1:0] adr,
   input  logic [1:0]           bte,
   output logic [adr_width-1:0] next_adr
);
   logic [adr_width-1:0] mask;
   // bits under the mask count, bits above it stay fixed, giving the wrap window
   assign mask = bte == bte_wrap4  ? adr_width'(3)  :
                 bte == bte_wrap8  ? adr_width'(7)  :
                 bte == bte_wrap16 ? adr_width'(15) : '1;
   assign next_adr = (adr & ~mask) | ((adr + 1'b1) & mask);
endmodule

// File: rtl/ram_wb_adapter.sv
// ram_wb_adapter: Wishbone B3 responder driving a single-port synchronous SRAM, RMW for partial writes
// wb_clk_i/wb_rst_i: clock, synchronous active-high reset
// bus (slave): Wishbone request/termination signals and the raw RAM port (adr/dat/we out, 1-cycle read data in)
// Build option RAM_WB_BURST_EN: incrementing read bursts via the BURST state and ram_wb_burst_addr.
module ram_wb_adapter import ram_wb_adapter_pkg::*; #(
   parameter int adr_width = 20,
   parameter int mem_size  = 262144
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   ram_wb_adapter_if.slave  bus
);
   state_t               state, state_n;
   logic [dat_width-1:0] dat_q, dat_n;
   logic                 ack_q, ack_n, err_q, err_n, we;
   logic [adr_width-1:0] idx;
   logic                 req, oor;
   logic                 unused_ok;
   assign idx = bus.wb_adr_i[adr_width+1:2];
   assign req = bus.wb_cyc_i & bus.wb_stb_i;
   assign oor = 32'(idx) >= 32'(mem_size);
   assign bus.wb_dat_o = dat_q;
   assign bus.wb_ack_o = ack_q;
   assign bus.wb_err_o = err_q;
   // reset must also kill a write already decoded this cycle (e.g. the RMW write)
   assign bus.ram_we_o = we & ~wb_rst_i;
`ifdef RAM_WB_BURST_EN
   logic [adr_width-1:0] burst_adr, burst_next;
   ram_wb_burst_addr #(.adr_width(adr_width)) u_burst_addr (
      .adr      (bus.ram_adr_o),
      .bte      (bus.wb_bte_i),
      .next_adr (burst_next)
   );
   // always one word ahead of the address being presented
   always_ff @(posedge wb_clk_i) burst_adr <= burst_next;
   assign unused_ok = ^{bus.wb_adr_i[31:adr_width+2], bus.wb_adr_i[1:0]};
`else
   assign unused_ok = ^{bus.wb_adr_i[31:adr_width+2], bus.wb_adr_i[1:0], bus.wb_cti_i, bus.wb_bte_i};
`endif
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
         dat_q <= '0;
         ack_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         dat_q <= dat_n;
         ack_q <= ack_n;
         err_q <= err_n;
      end
   end
   always_comb begin
      state_n       = state;
      dat_n         = dat_q;
      ack_n         = 1'b0;
      err_n         = 1'b0;
      we            = 1'b0;
      bus.ram_adr_o = idx;
      bus.ram_dat_o = bus.wb_dat_i;
      case (state)
         IDLE:
            if (req) begin
               if (oor) begin
                  err_n   = 1'b1;
                  state_n = ACK;
               end else if (!bus.wb_we_i) begin
`ifdef RAM_WB_BURST_EN
                  state_n = bus.wb_cti_i == cti_incr ? BURST : RD;
`else
                  state_n = RD;
`endif
               end else if (bus.wb_sel_i == 4'hF || bus.wb_sel_i == 4'h0) begin
                  we      = bus.wb_sel_i == 4'hF;
                  ack_n   = 1'b1;
                  state_n = ACK;
               end else begin
                  state_n = RMW;
               end
            end
         RD:
            if (!bus.wb_cyc_i) state_n = IDLE;
            else begin
               dat_n   = bus.ram_dat_i;
               ack_n   = 1'b1;
               state_n = ACK;
            end
         RMW:
            if (!bus.wb_cyc_i) state_n = IDLE;
            else begin
               we            = 1'b1;
               bus.ram_dat_o = merge_bytes(bus.ram_dat_i, bus.wb_dat_i, bus.wb_sel_i);
               ack_n         = 1'b1;
               state_n       = ACK;
            end
         ACK: state_n = IDLE;
`ifdef RAM_WB_BURST_EN
         // each cycle registers the word presented last cycle; the beat acked with cti END is the last
         BURST: begin
            bus.ram_adr_o = burst_adr;
            if (!bus.wb_cyc_i || (ack_q && bus.wb_cti_i == cti_end)) state_n = IDLE;
            else begin
               dat_n = bus.ram_dat_i;
               ack_n = 1'b1;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_ram_wb_adapter.sv
// tb_ram_wb_adapter: self-checking bench for ram_wb_adapter (vector table, corner sequences, random vs model)
module tb_ram_wb_adapter;
   localparam int mem_size = 262144;
   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        we;
      logic [31:0] exp_dat;
      int          exp_lat;
      logic        exp_err;
      int          exp_we;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   ram_wb_adapter_if bus ();
   ram_wb_adapter dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus));
   always #5 clk = ~clk;
   logic [31:0] ram [int];
   int          we_count = 0;
   logic        both_seen = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;
   function automatic logic [31:0] ram_rd(input int a);
      return ram.exists(a) ? ram[a] : 32'h0;
   endfunction
   always @(posedge clk) begin
      bus.ram_dat_i <= ram_rd(int'(bus.ram_adr_o));
      if (bus.ram_we_o) begin
         ram[int'(bus.ram_adr_o)] = bus.ram_dat_o;
         we_count = we_count + 1;
      end
   end
   always @(negedge clk) if (bus.wb_ack_o && bus.wb_err_o) both_seen = 1'b1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask
   task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, input logic we,
                       output logic [31:0] rdat, output int lat, output logic ack, output logic err);
      @(negedge clk);
      bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = sel; bus.wb_we_i = we;
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
      lat = 0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (bus.wb_ack_o || bus.wb_err_o) break;
      end
      ack = bus.wb_ack_o; err = bus.wb_err_o; rdat = bus.wb_dat_o;
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
   endtask
   vec_t        vecs [12];
   logic [31:0] model [16];
   logic [31:0] rdat, adr, dat;
   logic [3:0]  sel;
   logic        we, ack, err, oor;
   int          lat, w0, w, k, exp_lat, exp_we;
   logic [31:0] got [$];
   int          first_ack, last_ack;
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end
   initial begin
      vecs[0]  = '{32'h40,            32'h0,        4'hF, 1'b0, 32'hDEADBEEF, 2, 1'b0, 0};
      vecs[1]  = '{32'h40,            32'h12345678, 4'hF, 1'b1, 32'h0,        1, 1'b0, 1};
      vecs[2]  = '{32'h40,            32'h0,        4'hF, 1'b0, 32'h12345678, 2, 1'b0, 0};
      vecs[3]  = '{32'h0,             32'h11223344, 4'h5, 1'b1, 32'h0,        2, 1'b0, 1};
      vecs[4]  = '{32'h0,             32'h0,        4'hF, 1'b0, 32'hAA22CC44, 2, 1'b0, 0};
      vecs[5]  = '{32'h0,             32'hFFFFFFFF, 4'h0, 1'b1, 32'h0,        1, 1'b0, 0};
      vecs[6]  = '{32'h0,             32'h0,        4'hF, 1'b0, 32'hAA22CC44, 2, 1'b0, 0};
      vecs[7]  = '{mem_size * 4,      32'h0,        4'hF, 1'b0, 32'h0,        1, 1'b1, 0};
      vecs[8]  = '{mem_size * 4,      32'h99999999, 4'hF, 1'b1, 32'h0,        1, 1'b1, 0};
      vecs[9]  = '{(mem_size-1) * 4,  32'hCAFEF00D, 4'hF, 1'b1, 32'h0,        1, 1'b0, 1};
      vecs[10] = '{(mem_size-1) * 4,  32'h0,        4'hF, 1'b0, 32'hCAFEF00D, 2, 1'b0, 0};
      vecs[11] = '{(mem_size-1)*4+3,  32'h0,        4'h3, 1'b0, 32'hCAFEF00D, 2, 1'b0, 0};
      ram[32'h10] = 32'hDEADBEEF;
      ram[0] = 32'hAABBCCDD;
      for (int i = 0; i < 16; i++) begin
         ram[32'h100 + i] = (i * 32'h01010101) ^ 32'hA5A5A5A5;
         model[i] = (i * 32'h01010101) ^ 32'hA5A5A5A5;
      end
      for (int i = 4; i < 8; i++) ram[i] = i;
      bus.wb_adr_i = 0; bus.wb_dat_i = 0; bus.wb_sel_i = 0; bus.wb_we_i = 0;
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_cti_i = 0; bus.wb_bte_i = 0;
      repeat (3) @(negedge clk);
      chk("reset ack", bus.wb_ack_o, 0);
      chk("reset err", bus.wb_err_o, 0);
      chk("reset dat", bus.wb_dat_o, 0);
      chk("reset ram_we", bus.ram_we_o, 0);
      rst = 1'b0;
      foreach (vecs[i]) begin
         w0 = we_count;
         xfer(vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].we, rdat, lat, ack, err);
         chk($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("vec%0d err", i), err, vecs[i].exp_err);
         chk($sformatf("vec%0d ack", i), ack, !vecs[i].exp_err);
         chk($sformatf("vec%0d ram writes", i), we_count - w0, vecs[i].exp_we);
         if (!vecs[i].we && !vecs[i].exp_err) chk($sformatf("vec%0d rdata", i), rdat, vecs[i].exp_dat);
      end
      // read aborted in RD: no ack
      @(negedge clk);
      bus.wb_adr_i = 32'h40; bus.wb_we_i = 0; bus.wb_sel_i = 4'hF; bus.wb_cyc_i = 1; bus.wb_stb_i = 1;
      @(negedge clk);
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
      @(negedge clk);
      chk("abort rd ack", bus.wb_ack_o, 0);
      @(negedge clk);
      chk("abort rd ack later", bus.wb_ack_o, 0);
      // partial write aborted in RMW: no write
      w0 = we_count;
      bus.wb_adr_i = 32'h40; bus.wb_we_i = 1; bus.wb_sel_i = 4'h3; bus.wb_dat_i = 32'hFFFFFFFF;
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1;
      @(negedge clk);
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
      #1 chk("abort rmw ram_we", bus.ram_we_o, 0);
      @(negedge clk);
      chk("abort rmw ack", bus.wb_ack_o, 0);
      chk("abort rmw writes", we_count - w0, 0);
      xfer(32'h40, 0, 4'hF, 0, rdat, lat, ack, err);
      chk("abort rmw readback", rdat, 32'h12345678);
      // reset during the RMW write cycle
      w0 = we_count;
      @(negedge clk);
      bus.wb_adr_i = 32'h0; bus.wb_we_i = 1; bus.wb_sel_i = 4'h8; bus.wb_dat_i = 32'h55555555;
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1;
      @(negedge clk);
      rst = 1'b1;
      #1 chk("rst rmw ram_we", bus.ram_we_o, 0);
      @(negedge clk);
      chk("rst rmw ack", bus.wb_ack_o, 0);
      chk("rst rmw err", bus.wb_err_o, 0);
      chk("rst rmw dat", bus.wb_dat_o, 0);
      chk("rst rmw writes", we_count - w0, 0);
      rst = 1'b0; bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
      xfer(32'h0, 0, 4'hF, 0, rdat, lat, ack, err);
      chk("rst rmw readback", rdat, 32'hAA22CC44);
`ifdef RAM_WB_BURST_EN
      @(negedge clk);
      bus.wb_adr_i = 32'h18; bus.wb_we_i = 0; bus.wb_sel_i = 4'hF;
      bus.wb_cti_i = 3'b010; bus.wb_bte_i = 2'b01; bus.wb_cyc_i = 1; bus.wb_stb_i = 1;
      first_ack = 0; last_ack = 0;
      for (int c = 1; c <= 12 && got.size() < 4; c++) begin
         @(negedge clk);
         if (bus.wb_ack_o) begin
            if (got.size() == 0) first_ack = c;
            last_ack = c;
            got.push_back(bus.wb_dat_o);
            if (got.size() == 4) begin
               bus.wb_cti_i = 3'b111; bus.wb_stb_i = 0;
            end
         end
      end
      chk("burst first ack", first_ack, 2);
      chk("burst last ack", last_ack, 5);
      chk("burst beats", got.size(), 4);
      for (int i = 0; i < got.size(); i++) chk($sformatf("burst beat%0d", i), got[i], 32'((i + 2) % 4 + 4));
      @(negedge clk);
      chk("burst ack drop", bus.wb_ack_o, 0);
      bus.wb_cyc_i = 0; bus.wb_cti_i = 0; bus.wb_bte_i = 0;
      @(negedge clk);
`endif
      // random traffic against a word-level memory model
      repeat (40) begin
         oor = $urandom_range(7) == 0;
         w = $urandom_range(15);
         adr = oor ? (mem_size + $urandom_range(4000)) * 4 : (32'h100 + w) * 4;
         adr[1:0] = 2'($urandom_range(3));
         we = 1'($urandom_range(1));
         k = $urandom_range(3);
         sel = k == 0 ? 4'hF : k == 1 ? 4'h0 : 4'($urandom_range(15));
         dat = $urandom;
         exp_lat = oor || we && (sel == 4'hF || sel == 4'h0) ? 1 : 2;
         exp_we = !oor && we && sel != 0 ? 1 : 0;
         w0 = we_count;
         xfer(adr, dat, sel, we, rdat, lat, ack, err);
         chk("rand latency", lat, exp_lat);
         chk("rand err", err, oor);
         chk("rand ack", ack, !oor);
         chk("rand ram writes", we_count - w0, exp_we);
         if (!oor && !we) chk("rand rdata", rdat, model[w]);
         if (!oor && we) for (int b = 0; b < 4; b++) if (sel[b]) model[w][8*b +: 8] = dat[8*b +: 8];
      end
      for (int i = 0; i < 16; i++) begin
         xfer((32'h100 + i) * 4, 0, 4'hF, 0, rdat, lat, ack, err);
         chk($sformatf("final word%0d", i), rdat, model[i]);
      end
      chk("ack and err together", both_seen, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
